// File: rtl/rbt_s_parser_pkg.sv
// Shared definitions for the header-parser slice: metadata field map, tag indices, Ethernet header length.
// Fields sit above bit 224 so the low metadata bits stay free for upstream use.
package rbt_s_parser_pkg;

  localparam int ETH_HDR_LEN        = 14;

  localparam int SRC_PORT_NO        = 224;
  localparam int SRC_PORT_WIDTH     = 3;
  localparam int IP_OFFSET_NO       = 232;
  localparam int IP_OFFSET_WIDTH    = 8;
  localparam int PROTO_NO           = 240;
  localparam int PROTO_WIDTH        = 16;
  localparam int SEATL_OFFSET_NO    = 256;
  localparam int SEATL_OFFSET_WIDTH = 16;

  typedef enum logic [2:0] {
    TAG_ETH     = 3'd0,
    TAG_VLAN    = 3'd1,
    TAG_IPV4    = 3'd2,
    TAG_IPV6    = 3'd3,
    TAG_TCP     = 3'd4,
    TAG_UDP     = 3'd5,
    TAG_UNKNOWN = 3'd7
  } hdr_tag_e;

  localparam int TAG_COUNT = 8;

endpackage

// File: rtl/rbt_s_rr_arbiter.sv
// Round-robin pick: first requester at or after rr_ptr (mod PORTS) wins.
// Purely combinational, zero latency; no backpressure input, the parent gates the grant.
module rbt_s_rr_arbiter #(
  parameter int PORTS = 4,
  localparam int IDX_W = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [PORTS-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    idx       = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = 0; k < PORTS; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % PORTS);
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_vld) begin
      grant = PORTS'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/rbt_s_hdr_arbiter.sv
// Round-robin share of one header parser among PORTS sources; runts (< MIN_HDR_LEN) are dropped, source index stamped into metadata.
// Latency 1 cycle, 1 word/cycle; output stall (valid & ~ready) deasserts every in_proto_hdr_ready.
// Define RBT_S_HDR_ARB_STATS_EN for per-source saturating grant counters (stats_clr / stats_grant_cnt).
module rbt_s_hdr_arbiter
  import rbt_s_parser_pkg::*;
#(
  parameter int PORTS              = 4,
  parameter int HEADER_WIDTH       = 2048,
  parameter int PKT_METADATA_WIDTH = 272,
  parameter int SRC_PORT_NO        = rbt_s_parser_pkg::SRC_PORT_NO,
  parameter int SRC_PORT_WIDTH     = rbt_s_parser_pkg::SRC_PORT_WIDTH,
  parameter int MIN_HDR_LEN        = ETH_HDR_LEN
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [PORTS-1:0]                   in_proto_hdr_valid,
  output logic [PORTS-1:0]                   in_proto_hdr_ready,
  input  logic [PORTS*16-1:0]                in_proto_hdr_length,
  input  logic [PORTS*HEADER_WIDTH-1:0]      in_proto_hdr_data,
  input  logic [PORTS*PKT_METADATA_WIDTH-1:0] in_proto_hdr_pkt_metadata,
  output logic                               out_proto_hdr_valid,
  input  logic                               out_proto_hdr_ready,
  output logic [15:0]                        out_proto_hdr_length,
  output logic [HEADER_WIDTH-1:0]            out_proto_hdr_data,
  output logic [PKT_METADATA_WIDTH-1:0]      out_proto_hdr_pkt_metadata,
`ifdef RBT_S_HDR_ARB_STATS_EN
  input  logic                               stats_clr,
  output logic [PORTS*32-1:0]                stats_grant_cnt,
`endif
  output logic                               drop_pulse
);

  localparam int IDX_W = $clog2(PORTS);

  logic [PORTS-1:0]              grant;
  logic [IDX_W-1:0]              grant_idx;
  logic                          grant_vld;
  logic                          slot_free;
  logic                          accept;
  logic                          runt;

  logic [15:0]                   sel_len;
  logic [HEADER_WIDTH-1:0]       sel_dat;
  logic [PKT_METADATA_WIDTH-1:0] sel_meta;

  logic                          out_vld_q,  out_vld_d;
  logic [15:0]                   out_len_q,  out_len_d;
  logic [HEADER_WIDTH-1:0]       out_dat_q,  out_dat_d;
  logic [PKT_METADATA_WIDTH-1:0] out_meta_q, out_meta_d;
  logic                          drop_q,     drop_d;
  logic [IDX_W-1:0]              rr_ptr_q,   rr_ptr_d;

  rbt_s_rr_arbiter #(
    .PORTS(PORTS)
  ) u_rr_arbiter (
    .req       (in_proto_hdr_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Grant ignores ready, so a stalled output simply masks it here.
  assign slot_free          = ~out_vld_q | out_proto_hdr_ready;
  assign accept             = grant_vld & slot_free;
  assign in_proto_hdr_ready = grant & {PORTS{slot_free}};

  always_comb begin
    sel_len  = '0;
    sel_dat  = '0;
    sel_meta = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant[i]) begin
        sel_len  = in_proto_hdr_length[i*16 +: 16];
        sel_dat  = in_proto_hdr_data[i*HEADER_WIDTH +: HEADER_WIDTH];
        sel_meta = in_proto_hdr_pkt_metadata[i*PKT_METADATA_WIDTH +: PKT_METADATA_WIDTH];
      end
    end
    sel_meta[SRC_PORT_NO +: SRC_PORT_WIDTH] = SRC_PORT_WIDTH'(grant_idx);
  end

  assign runt = sel_len < 16'(MIN_HDR_LEN);

  always_comb begin
    out_vld_d  = out_vld_q & ~out_proto_hdr_ready;
    out_len_d  = out_len_q;
    out_dat_d  = out_dat_q;
    out_meta_d = out_meta_q;
    drop_d     = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == IDX_W'(PORTS - 1)) ? '0 : grant_idx + 1'b1;
      if (runt) begin
        drop_d = 1'b1;
      end else begin
        out_vld_d  = 1'b1;
        out_len_d  = sel_len;
        out_dat_d  = sel_dat;
        out_meta_d = sel_meta;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_len_q  <= '0;
      out_dat_q  <= '0;
      out_meta_q <= '0;
      drop_q     <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_len_q  <= out_len_d;
      out_dat_q  <= out_dat_d;
      out_meta_q <= out_meta_d;
      drop_q     <= drop_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign out_proto_hdr_valid        = out_vld_q;
  assign out_proto_hdr_length       = out_len_q;
  assign out_proto_hdr_data         = out_dat_q;
  assign out_proto_hdr_pkt_metadata = out_meta_q;
  assign drop_pulse                 = drop_q;

`ifdef RBT_S_HDR_ARB_STATS_EN
  logic [31:0] cnt_q [PORTS];
  logic [31:0] cnt_d [PORTS];

  // Runts count as grants; clear beats a same-cycle increment.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (accept && grant[i] && (cnt_q[i] != 32'hFFFF_FFFF)) begin
        cnt_d[i] = cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PORTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    stats_grant_cnt = '0;
    for (int i = 0; i < PORTS; i++) begin
      stats_grant_cnt[i*32 +: 32] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_rbt_s_hdr_arbiter.sv
// Directed plus random stimulus against a cycle-level reference model of the header arbiter.
// Outputs are sampled 1 time unit after the falling edge, inputs change on the falling edge.
module tb_rbt_s_hdr_arbiter;

  localparam int P    = 4;
  localparam int HW   = 2048;
  localparam int MW   = 272;
  localparam int SPN  = 224;
  localparam int SPW  = 3;
  localparam int MINL = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [P-1:0]    in_vld;
  logic [P-1:0]    in_rdy;
  logic [P*16-1:0] in_len;
  logic [P*HW-1:0] in_dat;
  logic [P*MW-1:0] in_meta;
  logic            out_vld;
  logic            out_rdy;
  logic [15:0]     out_len;
  logic [HW-1:0]   out_dat;
  logic [MW-1:0]   out_meta;
  logic            drop;
`ifdef RBT_S_HDR_ARB_STATS_EN
  logic            stats_clr;
  logic [P*32-1:0] stats_cnt;
`endif

  rbt_s_hdr_arbiter dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .in_proto_hdr_valid         (in_vld),
    .in_proto_hdr_ready         (in_rdy),
    .in_proto_hdr_length        (in_len),
    .in_proto_hdr_data          (in_dat),
    .in_proto_hdr_pkt_metadata  (in_meta),
    .out_proto_hdr_valid        (out_vld),
    .out_proto_hdr_ready        (out_rdy),
    .out_proto_hdr_length       (out_len),
    .out_proto_hdr_data         (out_dat),
    .out_proto_hdr_pkt_metadata (out_meta),
`ifdef RBT_S_HDR_ARB_STATS_EN
    .stats_clr                  (stats_clr),
    .stats_grant_cnt            (stats_cnt),
`endif
    .drop_pulse                 (drop)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: what the parser should currently see.
  logic          m_vld;
  logic          m_drop;
  logic [15:0]   m_len;
  logic [HW-1:0] m_dat;
  logic [MW-1:0] m_meta;
  int            m_rr;
  logic [31:0]   m_cnt [P];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got ..%h want ..%h (low 64 bits)", tag, obs[63:0], exp[63:0]);
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_drop = 1'b0;
    m_len  = '0;
    m_dat  = '0;
    m_meta = '0;
    m_rr   = 0;
    for (int i = 0; i < P; i++) m_cnt[i] = '0;
  endtask

  task automatic rnd_word(input int i, input int len);
    for (int w = 0; w < HW / 32; w++) in_dat[i*HW + w*32 +: 32] = $urandom;
    for (int w = 0; w < MW / 16; w++) in_meta[i*MW + w*16 +: 16] = 16'($urandom);
    in_len[i*16 +: 16] = 16'(len);
  endtask

  // Called on a falling edge with inputs already driven; returns on the next falling edge.
  task automatic tick();
    int           g;
    logic         slot;
    logic         acc;
    logic [P-1:0] er;
    #1;
    slot = !m_vld || out_rdy;
    g = -1;
    for (int k = 0; k < P; k++) begin
      if (g < 0 && in_vld[(m_rr + k) % P]) g = (m_rr + k) % P;
    end
    acc = (g >= 0) && slot;
    er  = acc ? (P'(1) << g) : '0;
    chk("in_ready", 64'(in_rdy), 64'(er));
    chk("out_valid", 64'(out_vld), 64'(m_vld));
    chk("drop_pulse", 64'(drop), 64'(m_drop));
    chk("out_length", 64'(out_len), 64'(m_len));
    chk_w("out_data", out_dat, m_dat);
    chk_w("out_meta", HW'(out_meta), HW'(m_meta));
`ifdef RBT_S_HDR_ARB_STATS_EN
    for (int i = 0; i < P; i++) chk("grant_cnt", 64'(stats_cnt[i*32 +: 32]), 64'(m_cnt[i]));
`endif
    @(posedge clk);
    m_drop = 1'b0;
    if (m_vld && out_rdy) m_vld = 1'b0;
    if (acc) begin
      m_rr = (g + 1) % P;
      if (in_len[g*16 +: 16] >= 16'(MINL)) begin
        m_vld  = 1'b1;
        m_len  = in_len[g*16 +: 16];
        m_dat  = in_dat[g*HW +: HW];
        m_meta = in_meta[g*MW +: MW];
        m_meta[SPN +: SPW] = SPW'(g);
      end else begin
        m_drop = 1'b1;
      end
    end
`ifdef RBT_S_HDR_ARB_STATS_EN
    for (int i = 0; i < P; i++) begin
      if (stats_clr) m_cnt[i] = '0;
      else if (acc && g == i && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    in_vld  = '0;
    in_len  = '0;
    in_dat  = '0;
    in_meta = '0;
    out_rdy = 1'b1;
`ifdef RBT_S_HDR_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();

    // Reset values while rst_n is held low.
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    tick();

    // All four sources valid: strict rotation 0,1,2,3,0,... one word per cycle.
    in_vld = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < P; i++) rnd_word(i, $urandom_range(MINL, 200));
      tick();
    end
    in_vld = '0;
    tick();

    // Lone source 2 with length 64.
    in_vld = 4'b0100;
    rnd_word(2, 64);
    tick();
    in_vld = '0;
    tick();
    chk("lone_src_field", 64'(out_meta[SPN +: SPW]), 64'd2);
    tick();

    // Output stall for 5 cycles with sources 0 and 1 requesting.
    in_vld = 4'b0001;
    rnd_word(0, 40);
    tick();
    out_rdy = 1'b0;
    in_vld  = 4'b0011;
    rnd_word(0, 50);
    rnd_word(1, 60);
    for (int c = 0; c < 5; c++) tick();
    out_rdy = 1'b1;
    tick();
    tick();
    in_vld = '0;
    tick();

    // Runt from source 1, then sources 1 and 2 compete.
    in_vld = 4'b0010;
    rnd_word(1, 10);
    tick();
    in_vld = 4'b0110;
    rnd_word(1, 30);
    rnd_word(2, 30);
    tick();
    in_vld = '0;
    tick();
    tick();

    // Boundary lengths around the runt threshold.
    in_vld = 4'b1000;
    rnd_word(3, MINL - 1);
    tick();
    rnd_word(3, MINL);
    tick();
    rnd_word(3, 0);
    tick();
    in_vld = '0;
    tick();

    // Random traffic with random parser backpressure.
    for (int c = 0; c < 300; c++) begin
      in_vld = P'($urandom_range(0, 15));
      for (int i = 0; i < P; i++) rnd_word(i, $urandom_range(0, 40));
      out_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_vld  = '0;
    out_rdy = 1'b1;
    tick();

    // Reset pulse while the output is stalled and valid.
    in_vld = 4'b0010;
    rnd_word(1, 30);
    tick();
    out_rdy = 1'b0;
    in_vld  = 4'b0011;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_vld), 64'd0);
    chk("rst_out_length", 64'(out_len), 64'd0);
    chk_w("rst_out_data", out_dat, '0);
    model_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    in_vld  = 4'b1111;
    for (int i = 0; i < P; i++) rnd_word(i, 20);
    tick();
    tick();
    in_vld = '0;
    tick();

`ifdef RBT_S_HDR_ARB_STATS_EN
    // Three grants to source 3, then clear colliding with a source-3 accept.
    in_vld = 4'b1000;
    rnd_word(3, 20);
    for (int c = 0; c < 3; c++) tick();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    in_vld    = '0;
    tick();
    chk("clr_wins", 64'(stats_cnt[3*32 +: 32]), 64'd0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
